// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider.
package div_pkg;

  // Default operand/result width.
  localparam int DEF_W = 16;

  // Control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_ctrl_fsm.sv
// Control FSM for the repeated-subtraction divider: sequences load,
// one subtraction per clock, result capture and the done pulse.
module div_ctrl_fsm
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,     // synchronous, active-low
  input  logic start,
  input  logic dz,      // divisor input is zero
  input  logic a_ge_b,  // working remainder >= divisor
  output logic ld,      // load A/B/Q from operands
  output logic sub,     // A <= A-B, Q <= Q+1
  output logic fin,     // capture results (quotient/remainder/flag)
  output logic busy,
  output logic done
);

  state_e state_q, state_d;

  // State register; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
    state_d = state_q;
    ld      = 1'b0;
    sub     = 1'b0;
    fin     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dz) begin
            fin     = 1'b1;
            state_d = DONE;
          end else begin
            ld      = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (a_ge_b) begin
          sub = 1'b1;
        end else begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: A holds the running
// remainder, B the divisor, Q the count of subtractions so far.
module div_repsub
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,          // synchronous, active-low
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;

  logic ld, sub, fin;
  logic dz, a_ge_b;

  assign dz     = (divisor == '0);
  assign a_ge_b = (a_q >= b_q);

  div_ctrl_fsm u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dz     (dz),
    .a_ge_b (a_ge_b),
    .ld     (ld),
    .sub    (sub),
    .fin    (fin),
    .busy   (busy),
    .done   (done)
  );

  // Datapath next-state: load, subtract, or capture results.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    q_d   = q_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (ld) begin
      a_d = dividend;
      b_d = divisor;
      q_d = '0;
    end
    if (sub) begin
      a_d = a_q - b_q;       // guarded by a_ge_b, never underflows
      q_d = q_q + W'(1);     // bounded by the dividend, never wraps
    end
    if (fin) begin
      // fin while not busy can only be the divide-by-zero shortcut from IDLE.
      if (busy) begin
        quo_d = q_q;
        rem_d = a_q;
        dbz_d = 1'b0;
      end else begin
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
